// File: rtl/loader_pkg.sv
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  // Loader states; S_CKSUM is only reachable with LOADER_CHECKSUM_EN defined.
  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CKSUM  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // Length header is a big-endian 16-bit word count.
  localparam int HDR_BYTES           = 2;
  localparam int DEFAULT_DEPTH_WORDS = 128;

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module   : imem_array
// Purpose  : DEPTH_WORDS x 32 instruction store, one synchronous write port
//            and one combinational read port. Contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Synchronous write; the new word is readable from the following cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read for the CPU fetch path.
  always_comb begin
    rdata_o = mem[raddr_i];
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Boot-time loader. Receives a length header and big-endian byte
//            stream, writes words into the instruction store, serves the CPU
//            fetch port and holds the CPU in reset until the load completes.
//            Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum
//            byte that must match before the CPU is released.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int ADDR_W      = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic [31:0]       pc_addr_i,
  output logic [31:0]       instr_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [31:0] FETCH_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [15:0] MAX_N       = 16'(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  logic              xfer;
  logic [15:0]       n_new;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  // Ready is forced low while reset is asserted so no byte can slip in.
  always_comb begin
    byte_ready_o = !rst_i && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                              state_q == S_DATA   || state_q == S_CKSUM);
    xfer         = byte_valid_i && byte_ready_o;
    n_new        = {n_q[15:8], byte_data_i};
    wdata        = {word_q, byte_data_i};
  end

  // Next-state, header/word assembly and registered-output decode.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    lane_d  = lane_q;
    word_d  = word_q;
    words_d = words_q;
    we      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    cksum_d = cksum_q;
    if (xfer && state_q != S_CKSUM) begin
      cksum_d = cksum_q ^ byte_data_i;
    end
`endif
    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          n_d     = {byte_data_i, n_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d = n_new;
          if (n_new == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_DONE;
`endif
          end else if (n_new > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          lane_d = 2'(lane_q + 2'd1);
          case (lane_q)
            2'd0: word_d[23:16] = byte_data_i;
            2'd1: word_d[15:8]  = byte_data_i;
            2'd2: word_d[7:0]   = byte_data_i;
            default: begin
              we      = 1'b1;
              words_d = words_q + (ADDR_W+1)'(1);
              if (16'(words_d) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = S_CKSUM;
`else
                state_d = S_DONE;
`endif
              end
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (xfer) begin
          state_d = (byte_data_i == cksum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = state_q;
    endcase
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_LEN_HI;
      n_q       <= 16'd0;
      lane_q    <= 2'd0;
      word_q    <= 24'd0;
      words_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cksum_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      words_q   <= words_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_imem_array (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (words_q[ADDR_W-1:0]),
    .wdata_i (wdata),
    .raddr_i (pc_addr_i[ADDR_W+1:2]),
    .rdata_o (rdata)
  );

  // Fetch returns zero outside the implemented address range.
  always_comb begin
    instr_o        = (pc_addr_i < FETCH_LIMIT) ? rdata : 32'h0;
    cpu_rst_o      = cpu_rst_q;
    load_done_o    = done_q;
    load_err_o     = err_q;
    words_loaded_o = words_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Directed self-checking bench for instr_mem_loader. Follows the
//            LOADER_CHECKSUM_EN macro so the same stream works in both builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] pc_addr = 32'h0;
  logic [31:0] instr;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [7:0]  words_loaded;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tb_x = 8'h00;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .DEPTH_WORDS (128),
    .ADDR_W      (7)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .byte_data_i    (byte_data),
    .byte_valid_i   (byte_valid),
    .byte_ready_o   (byte_ready),
    .pc_addr_i      (pc_addr),
    .instr_o        (instr),
    .cpu_rst_o      (cpu_rst),
    .load_done_o    (load_done),
    .load_err_o     (load_err),
    .words_loaded_o (words_loaded)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
    pc_addr = addr;
    #1;
    chk($sformatf("fetch_%h", addr), instr, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    #1;
    chk("ready_in_reset", {31'd0, byte_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_words", {24'd0, words_loaded}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    tb_x = 8'h00;
    #1;
    chk("ready_after_reset", {31'd0, byte_ready}, 32'd1);
  endtask

  // Present a byte at the negedge and hold it until it transfers.
  task automatic send_byte(input logic [7:0] b, input bit need_ready);
    int waitc;
    waitc = 0;
    @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    if (need_ready) chk("ready_now", {31'd0, byte_ready}, 32'd1);
    while (!byte_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!byte_ready) chk("ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    tb_x = tb_x ^ b;
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  // Last byte of a successful load: CPU held before the edge, released after.
  task automatic final_byte(input logic [7:0] b);
    @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    chk("pre_last_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("pre_last_ready", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    tb_x = tb_x ^ b;
    #1;
    chk("post_last_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("post_last_done", {31'd0, load_done}, 32'd1);
    chk("post_last_ready", {31'd0, byte_ready}, 32'd0);
  endtask

  task automatic finish_data(input logic [7:0] last);
`ifdef LOADER_CHECKSUM_EN
    send_byte(last, 1'b1);
    final_byte(tb_x);
`else
    final_byte(last);
`endif
  endtask

  initial begin
    do_reset();
    fetch(32'h0000_0200, 32'h0);
    fetch(32'hFFFF_FFFC, 32'h0);

    // Two-word load, valid held high.
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1); send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    finish_data(8'h0D);
    chk("t1_words", {24'd0, words_loaded}, 32'd2);
    chk("t1_err", {31'd0, load_err}, 32'd0);
    fetch(32'h0000_0000, 32'h2008_0005);
    fetch(32'h0000_0004, 32'h0000_000D);
    fetch(32'h0000_0007, 32'h0000_000D);
    // Done is sticky and refuses further bytes.
    @(negedge clk); byte_data = 8'hFF; byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_bp_ready", {31'd0, byte_ready}, 32'd0);
    end
    chk("t1_bp_words", {24'd0, words_loaded}, 32'd2);
    chk("t1_bp_done", {31'd0, load_done}, 32'd1);

    // Empty program.
    do_reset();
    send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
    final_byte(8'h00);
`else
    final_byte(8'h00);
`endif
    chk("t2_words", {24'd0, words_loaded}, 32'd0);
    chk("t2_err", {31'd0, load_err}, 32'd0);

    // Oversized length header.
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h81, 1'b1);
    chk("t3_err", {31'd0, load_err}, 32'd1);
    chk("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t3_done", {31'd0, load_done}, 32'd0);
    chk("t3_ready", {31'd0, byte_ready}, 32'd0);
    @(negedge clk); byte_data = 8'h12; byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t3_bp_ready", {31'd0, byte_ready}, 32'd0);
    end
    chk("t3_bp_words", {24'd0, words_loaded}, 32'd0);
    chk("t3_bp_err", {31'd0, load_err}, 32'd1);

    // Three-word load with random valid gaps.
    do_reset();
    idle($urandom_range(0, 3)); send_byte(8'h00, 1'b0);
    idle($urandom_range(0, 3)); send_byte(8'h03, 1'b0);
    begin
      logic [7:0] pay [12];
      pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'hA5, 8'h5A, 8'h5A,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < 11; i++) begin
        idle($urandom_range(0, 3));
        send_byte(pay[i], 1'b0);
      end
      idle($urandom_range(1, 3));
      finish_data(pay[11]);
    end
    chk("t4_words", {24'd0, words_loaded}, 32'd3);
    fetch(32'h0000_0000, 32'h0102_0304);
    fetch(32'h0000_0004, 32'hA5A5_5A5A);
    fetch(32'h0000_0008, 32'hDEAD_BEEF);

    // Reset in the middle of a two-word load, then reload one word.
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    chk("t5_partial_words", {24'd0, words_loaded}, 32'd1);
    do_reset();
    fetch(32'h0000_0000, 32'h1122_3344);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    finish_data(8'hDD);
    chk("t5_words", {24'd0, words_loaded}, 32'd1);
    fetch(32'h0000_0000, 32'hAABB_CCDD);
    fetch(32'h0000_0004, 32'hA5A5_5A5A);

`ifdef LOADER_CHECKSUM_EN
    // Correct checksum releases the CPU.
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    final_byte(8'h45);
    fetch(32'h0000_0000, 32'h1122_3344);
    // Wrong checksum keeps the CPU in reset.
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
    send_byte(8'h46, 1'b1);
    chk("t6_err", {31'd0, load_err}, 32'd1);
    chk("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t6_done", {31'd0, load_done}, 32'd0);
    fetch(32'h0000_0000, 32'h5566_7788);
`endif

    fetch(32'h0000_0200, 32'h0);
    byte_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
